// File: rtl/exe_wb_arbiter.sv
// Execute-stage writeback arbiter: merges the divider result pulse and the
// ALU result stream onto one register-file write port. ALU results that lose
// to the divider wait in an in-order skid FIFO. Also tracks the destination
// of the in-flight division for decode hazard detection.
module exe_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_en_in,
  input  logic [AW-1:0] alu_addr_in,
  input  logic [DW-1:0] alu_result_in,
  output logic          alu_ready,
  input  logic          div_issue,
  input  logic [AW-1:0] div_issue_addr,
  input  logic          div_en_in,
  input  logic [AW-1:0] div_addr_in,
  input  logic [DW-1:0] div_result_in,
  input  logic [AW-1:0] rj_addr,
  input  logic [AW-1:0] rk_addr,
  output logic          div_hazard,
  output logic          div_pending,
  output logic          wb_en,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Skid FIFO storage (no reset: validity is carried by the count)
  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;

  logic          wb_en_reg, wb_en_next;
  logic [AW-1:0] wb_addr_reg, wb_addr_next;
  logic [DW-1:0] wb_data_reg, wb_data_next;

  logic          pending_reg, pending_next;
  logic [AW-1:0] pending_addr_reg, pending_addr_next;
  logic          overflow_reg, overflow_next;

  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          sel_bypass;
  logic          win_valid;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;

  // Pointers wrap at DEPTH, which need not be a power of two
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign fifo_empty = (count_reg == '0);
  // Deliberately no look-ahead at a same-cycle pop
  assign alu_ready  = (count_reg != FULL_CNT);

  // Winner selection: divider pulse, then FIFO head, then ALU bypass
  always_comb begin
    sel_bypass = 1'b0;
    pop        = 1'b0;
    win_valid  = 1'b0;
    win_addr   = '0;
    win_data   = '0;
    if (div_en_in) begin
      win_valid = 1'b1;
      win_addr  = div_addr_in;
      win_data  = div_result_in;
    end else if (!fifo_empty) begin
      pop       = 1'b1;
      win_valid = 1'b1;
      win_addr  = addr_mem[rd_ptr_reg];
      win_data  = data_mem[rd_ptr_reg];
    end else if (alu_en_in) begin
      sel_bypass = 1'b1;
      win_valid  = 1'b1;
      win_addr   = alu_addr_in;
      win_data   = alu_result_in;
    end
    push = alu_en_in && alu_ready && !sel_bypass;
  end

  // Next-state for FIFO bookkeeping, writeback port, scoreboard and overflow
  always_comb begin
    rd_ptr_next       = pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    wr_ptr_next       = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    count_next        = count_reg;
    wb_en_next        = 1'b0;
    wb_addr_next      = wb_addr_reg;
    wb_data_next      = wb_data_reg;
    pending_next      = pending_reg;
    pending_addr_next = pending_addr_reg;
    overflow_next     = overflow_reg | (alu_en_in & ~alu_ready);

    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase

    if (win_valid) begin
      // r0 is hardwired: consume the result but suppress the write
      wb_en_next   = (win_addr != '0);
      wb_addr_next = win_addr;
      wb_data_next = win_data;
    end

    // A new issue outranks the completion pulse of the previous division
    if (div_issue) begin
      pending_next      = 1'b1;
      pending_addr_next = div_issue_addr;
    end else if (div_en_in) begin
      pending_next = 1'b0;
    end
  end

  // FIFO tail write
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= alu_addr_in;
      data_mem[wr_ptr_reg] <= alu_result_in;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg       <= '0;
      wr_ptr_reg       <= '0;
      count_reg        <= '0;
      wb_en_reg        <= 1'b0;
      wb_addr_reg      <= '0;
      wb_data_reg      <= '0;
      pending_reg      <= 1'b0;
      pending_addr_reg <= '0;
      overflow_reg     <= 1'b0;
    end else begin
      rd_ptr_reg       <= rd_ptr_next;
      wr_ptr_reg       <= wr_ptr_next;
      count_reg        <= count_next;
      wb_en_reg        <= wb_en_next;
      wb_addr_reg      <= wb_addr_next;
      wb_data_reg      <= wb_data_next;
      pending_reg      <= pending_next;
      pending_addr_reg <= pending_addr_next;
      overflow_reg     <= overflow_next;
    end
  end

  assign wb_en       = wb_en_reg;
  assign wb_addr     = wb_addr_reg;
  assign wb_data     = wb_data_reg;
  assign div_pending = pending_reg;
  assign overflow    = overflow_reg;
  assign div_hazard  = pending_reg && (pending_addr_reg != '0) &&
                       ((rj_addr == pending_addr_reg) || (rk_addr == pending_addr_reg));

endmodule

// File: tb/tb_exe_wb_arbiter.sv
// Self-checking bench for exe_wb_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based behavioural model.
module tb_exe_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int DW    = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_en_in;
  logic [AW-1:0] alu_addr_in;
  logic [DW-1:0] alu_result_in;
  logic          alu_ready;
  logic          div_issue;
  logic [AW-1:0] div_issue_addr;
  logic          div_en_in;
  logic [AW-1:0] div_addr_in;
  logic [DW-1:0] div_result_in;
  logic [AW-1:0] rj_addr;
  logic [AW-1:0] rk_addr;
  logic          div_hazard;
  logic          div_pending;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          overflow;

  always #5 clk = ~clk;

  exe_wb_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_en_in(alu_en_in), .alu_addr_in(alu_addr_in), .alu_result_in(alu_result_in),
    .alu_ready(alu_ready),
    .div_issue(div_issue), .div_issue_addr(div_issue_addr),
    .div_en_in(div_en_in), .div_addr_in(div_addr_in), .div_result_in(div_result_in),
    .rj_addr(rj_addr), .rk_addr(rk_addr),
    .div_hazard(div_hazard), .div_pending(div_pending),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .overflow(overflow)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  // Behavioural model
  ent_t          m_q[$];
  logic          m_valid = 1'b0;
  logic          m_wb_en;
  logic [AW-1:0] m_wb_addr;
  logic [DW-1:0] m_wb_data;
  logic          m_pending;
  logic [AW-1:0] m_paddr;
  logic          m_ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; alu_en_in = 1'b0; alu_addr_in = '0; alu_result_in = '0;
    div_issue = 1'b0; div_issue_addr = '0; div_en_in = 1'b0; div_addr_in = '0;
    div_result_in = '0; rj_addr = '0; rk_addr = '0;
  endtask

  // Compare DUT against the model, then advance model and DUT by one cycle.
  // Called at a negedge with inputs already applied.
  task automatic step();
    ent_t e;
    logic          have_win;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    #1;
    if (m_valid) begin
      chk("alu_ready",   {31'd0, alu_ready},   {31'd0, (m_q.size() < DEPTH)});
      chk("div_pending", {31'd0, div_pending}, {31'd0, m_pending});
      chk("div_hazard",  {31'd0, div_hazard},
          {31'd0, m_pending && m_paddr != 0 && (rj_addr == m_paddr || rk_addr == m_paddr)});
      chk("overflow",    {31'd0, overflow},    {31'd0, m_ovf});
      chk("wb_en",       {31'd0, wb_en},       {31'd0, m_wb_en});
      chk("wb_addr",     {27'd0, wb_addr},     {27'd0, m_wb_addr});
      chk("wb_data",     wb_data,              m_wb_data);
    end
    if (rst) begin
      m_q.delete();
      m_wb_en = 0; m_wb_addr = 0; m_wb_data = 0;
      m_pending = 0; m_paddr = 0; m_ovf = 0;
      m_valid = 1'b1;
    end else begin
      // Arrivals join the back of the line; the divider jumps the line,
      // otherwise the oldest ALU result goes out.
      if (alu_en_in) begin
        if (m_q.size() < DEPTH) begin
          e.addr = alu_addr_in; e.data = alu_result_in;
          m_q.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
      have_win = 1'b0; w_addr = '0; w_data = '0;
      if (div_en_in) begin
        have_win = 1'b1; w_addr = div_addr_in; w_data = div_result_in;
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        have_win = 1'b1; w_addr = e.addr; w_data = e.data;
      end
      if (have_win) begin
        m_wb_en = (w_addr != 0); m_wb_addr = w_addr; m_wb_data = w_data;
      end else begin
        m_wb_en = 1'b0;
      end
      if (div_issue) begin
        m_pending = 1'b1; m_paddr = div_issue_addr;
      end else if (div_en_in) begin
        m_pending = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic alu(input logic [AW-1:0] a, input logic [DW-1:0] d);
    alu_en_in = 1'b1; alu_addr_in = a; alu_result_in = d;
  endtask

  task automatic divr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    div_en_in = 1'b1; div_addr_in = a; div_result_in = d;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    step();
    step();
    idle();
    step();
    chk("reset wb_en", {31'd0, wb_en}, 32'd0);
    chk("reset alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("reset div_pending", {31'd0, div_pending}, 32'd0);
    chk("reset overflow", {31'd0, overflow}, 32'd0);
    chk("reset wb_data", wb_data, 32'd0);
    $display("txn reset done");

    // Bypass
    idle(); alu(5'd3, 32'h11); step();
    chk("bypass wb_en", {31'd0, wb_en}, 32'd1);
    chk("bypass wb_addr", {27'd0, wb_addr}, 32'd3);
    chk("bypass wb_data", wb_data, 32'h11);
    chk("bypass alu_ready", {31'd0, alu_ready}, 32'd1);
    $display("txn bypass r3=0x11");

    // Collision
    idle(); divr(5'd5, 32'hAAAA); alu(5'd6, 32'hBBBB); step();
    chk("coll div addr", {27'd0, wb_addr}, 32'd5);
    chk("coll div data", wb_data, 32'hAAAA);
    chk("coll ready", {31'd0, alu_ready}, 32'd1);
    idle(); step();
    chk("coll alu en", {31'd0, wb_en}, 32'd1);
    chk("coll alu addr", {27'd0, wb_addr}, 32'd6);
    chk("coll alu data", wb_data, 32'hBBBB);
    $display("txn collision r5 then r6");

    // Order and fill
    idle(); divr(5'd10, 32'd100); alu(5'd1, 32'd1); step();
    idle(); divr(5'd11, 32'd101); alu(5'd2, 32'd2); step();
    idle(); divr(5'd12, 32'd102); alu(5'd3, 32'd3); #1;
    chk("fill ready low", {31'd0, alu_ready}, 32'd0);
    step();
    chk("fill overflow", {31'd0, overflow}, 32'd1);
    idle(); step();
    chk("fill r1 addr", {27'd0, wb_addr}, 32'd1);
    chk("fill r1 data", wb_data, 32'd1);
    step();
    chk("fill r2 addr", {27'd0, wb_addr}, 32'd2);
    chk("fill r2 data", wb_data, 32'd2);
    step();
    chk("fill no r3", {31'd0, wb_en}, 32'd0);
    $display("txn order/fill r1,r2 written, r3 dropped");
    idle(); rst = 1'b1; step(); idle();

    // r0 suppression
    idle(); alu(5'd0, 32'hFFFF); step();
    chk("r0 wb_en", {31'd0, wb_en}, 32'd0);
    idle(); alu(5'd4, 32'h44); step();
    chk("r4 wb_en", {31'd0, wb_en}, 32'd1);
    chk("r4 wb_addr", {27'd0, wb_addr}, 32'd4);
    $display("txn r0 suppressed, r4 written");

    // Scoreboard
    idle(); div_issue = 1'b1; div_issue_addr = 5'd7; step();
    idle(); rj_addr = 5'd7; rk_addr = 5'd8; #1;
    chk("sb pending", {31'd0, div_pending}, 32'd1);
    chk("sb hazard rj", {31'd0, div_hazard}, 32'd1);
    step();
    idle(); rk_addr = 5'd8; #1;
    chk("sb hazard rk8", {31'd0, div_hazard}, 32'd0);
    divr(5'd7, 32'h77); step();
    chk("sb cleared", {31'd0, div_pending}, 32'd0);
    idle(); div_issue = 1'b1; div_issue_addr = 5'd0; step();
    idle(); #1;
    chk("sb r0 pending", {31'd0, div_pending}, 32'd1);
    chk("sb r0 hazard", {31'd0, div_hazard}, 32'd0);
    $display("txn scoreboard set/clear/r0");

    // Reset mid-queue
    idle(); divr(5'd9, 32'h9); alu(5'd1, 32'h21); step();
    idle(); divr(5'd9, 32'h9); alu(5'd2, 32'h22); div_issue = 1'b1; div_issue_addr = 5'd12; step();
    idle(); #1;
    chk("rq full", {31'd0, alu_ready}, 32'd0);
    chk("rq pending", {31'd0, div_pending}, 32'd1);
    rst = 1'b1; step();
    idle(); #1;
    chk("rq ready", {31'd0, alu_ready}, 32'd1);
    chk("rq wb_en", {31'd0, wb_en}, 32'd0);
    chk("rq pending clr", {31'd0, div_pending}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rq no stale", {31'd0, wb_en}, 32'd0);
    end
    $display("txn reset mid-queue");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      idle();
      rst            = ($urandom_range(0, 199) == 0);
      alu_en_in      = ($urandom_range(0, 99) < 60);
      alu_addr_in    = AW'($urandom_range(0, 7));
      alu_result_in  = $urandom;
      div_en_in      = ($urandom_range(0, 99) < 30);
      div_addr_in    = AW'($urandom_range(0, 7));
      div_result_in  = $urandom;
      div_issue      = ($urandom_range(0, 99) < 15);
      div_issue_addr = AW'($urandom_range(0, 7));
      rj_addr        = AW'($urandom_range(0, 7));
      rk_addr        = AW'($urandom_range(0, 7));
      step();
      if (m_wb_en)
        $display("txn %0d: wb r%0d=0x%0h", cyc, m_wb_addr, m_wb_data);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
